// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage. It holds the PC and the IF/ID pipeline register,
// and keeps at most one request to instruction memory outstanding. It also
// honours the hazard-unit stall inputs and flushes on EX branch redirects.
//
// Ports
//   clk, rst        : clock and synchronous active-high reset
//   pc_write        : 0 stalls the PC (hazard unit)
//   if_id_write     : 0 holds the IF/ID register (hazard unit)
//   branch_taken    : one-cycle redirect pulse from EX
//   branch_target   : redirect address (low two bits ignored)
//   imem_req        : fetch request valid (combinational)
//   imem_addr       : fetch address, word aligned (combinational)
//   imem_gnt        : memory accepts the request this cycle
//   imem_rvalid     : in-order response valid
//   imem_rdata      : response instruction word
//   pc_if_id        : IF/ID registered PC
//   instr_if_id     : IF/ID registered instruction
//   valid_if_id     : IF/ID holds a real instruction
//   fetch_busy      : a request is in flight or a response is parked
// ---------------------------------------------------------------------------
module if_fetch_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_write,
    input  logic            if_id_write,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] pc_if_id,
    output logic [XLEN-1:0] instr_if_id,
    output logic            valid_if_id,
    output logic            fetch_busy
);

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        WAIT  = 2'b01,
        HOLD  = 2'b10,
        DRAIN = 2'b11
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [XLEN-1:0] pc_r, pc_nxt_s;
    logic [XLEN-1:0] hold_r, hold_nxt_s;
    logic [XLEN-1:0] pc_if_id_nxt_s, instr_if_id_nxt_s;
    logic            valid_if_id_nxt_s;
    logic            advance_s;
    logic [XLEN-1:0] pc_plus4_s;
    logic [XLEN-1:0] redirect_pc_s;
    logic [1:0]      unused_tgt_s;

    assign advance_s     = pc_write & if_id_write;
    // Modulo-2^XLEN increment: wraps from the top word back to zero.
    assign pc_plus4_s    = pc_r + XLEN'(3'd4);
    assign redirect_pc_s = {branch_target[XLEN-1:2], 2'b00};
    assign unused_tgt_s  = branch_target[1:0];

    // A redirect suppresses the request so no grant can race the new PC.
    assign imem_req   = (state_r == FETCH) && !branch_taken;
    assign imem_addr  = pc_r;
    assign fetch_busy = (state_r != FETCH);

    // Next-state, next-PC, hold buffer and IF/ID update selection.
    always_comb begin
        state_nxt_s       = state_r;
        pc_nxt_s          = pc_r;
        hold_nxt_s        = hold_r;
        pc_if_id_nxt_s    = pc_if_id;
        instr_if_id_nxt_s = instr_if_id;
        valid_if_id_nxt_s = valid_if_id;

        if (branch_taken) begin
            // Redirect wins over stalls and over any response this cycle.
            pc_nxt_s          = redirect_pc_s;
            hold_nxt_s        = {XLEN{1'b0}};
            pc_if_id_nxt_s    = {XLEN{1'b0}};
            instr_if_id_nxt_s = NOP_INSTR;
            valid_if_id_nxt_s = 1'b0;
            case (state_r)
                FETCH:   state_nxt_s = FETCH;
                WAIT:    state_nxt_s = imem_rvalid ? FETCH : DRAIN;
                HOLD:    state_nxt_s = FETCH;
                DRAIN:   state_nxt_s = imem_rvalid ? FETCH : DRAIN;
                default: state_nxt_s = FETCH;
            endcase
        end else begin
            case (state_r)
                FETCH: begin
                    // PC stays put at grant; it advances on delivery.
                    if (imem_req && imem_gnt) begin
                        state_nxt_s = WAIT;
                    end else begin
                        state_nxt_s = FETCH;
                    end
                end
                WAIT: begin
                    if (imem_rvalid && advance_s) begin
                        pc_if_id_nxt_s    = pc_r;
                        instr_if_id_nxt_s = imem_rdata;
                        valid_if_id_nxt_s = 1'b1;
                        pc_nxt_s          = pc_plus4_s;
                        state_nxt_s       = FETCH;
                    end else if (imem_rvalid) begin
                        // Park the word until the hazard unit releases.
                        hold_nxt_s  = imem_rdata;
                        state_nxt_s = HOLD;
                    end else begin
                        state_nxt_s = WAIT;
                    end
                end
                HOLD: begin
                    if (advance_s) begin
                        pc_if_id_nxt_s    = pc_r;
                        instr_if_id_nxt_s = hold_r;
                        valid_if_id_nxt_s = 1'b1;
                        pc_nxt_s          = pc_plus4_s;
                        state_nxt_s       = FETCH;
                    end else begin
                        state_nxt_s = HOLD;
                    end
                end
                DRAIN: begin
                    // The killed request's data is discarded.
                    if (imem_rvalid) begin
                        state_nxt_s = FETCH;
                    end else begin
                        state_nxt_s = DRAIN;
                    end
                end
                default: state_nxt_s = FETCH;
            endcase
        end
    end

    // State, PC, hold buffer and IF/ID registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= FETCH;
            pc_r        <= RESET_PC;
            hold_r      <= {XLEN{1'b0}};
            pc_if_id    <= {XLEN{1'b0}};
            instr_if_id <= NOP_INSTR;
            valid_if_id <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            pc_r        <= pc_nxt_s;
            hold_r      <= hold_nxt_s;
            pc_if_id    <= pc_if_id_nxt_s;
            instr_if_id <= instr_if_id_nxt_s;
            valid_if_id <= valid_if_id_nxt_s;
        end
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage with PC register and IF/ID pipeline register. It sits directly upstream of the hazard detection unit and consumes its pc_write / if_id_write stall outputs. It issues one-outstanding requests to instruction memory and presents {pc, instr, valid} to decode. Branch redirects from EX flush the IF/ID register and discard in-flight fetches.

Parameters:
XLEN, 32, address/data width
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, instruction driven into IF/ID on flush/reset (addi x0,x0,0)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
pc_write  input  1  from hazard unit; 0 = stall PC
if_id_write  input  1  from hazard unit; 0 = hold IF/ID register
branch_taken  input  1  redirect request from EX (1-cycle pulse)
branch_target  input  XLEN  redirect address
imem_req  output  1  fetch request valid
imem_addr  output  XLEN  fetch address (word aligned)
imem_gnt  input  1  memory accepts request this cycle (imem_req & imem_gnt = handshake)
imem_rvalid  input  1  response valid; in order, >=1 cycle after grant
imem_rdata  input  XLEN  response instruction word
pc_if_id  output  XLEN  IF/ID registered PC
instr_if_id  output  XLEN  IF/ID registered instruction
valid_if_id  output  1  IF/ID holds a real instruction
fetch_busy  output  1  state != FETCH

Behaviour:
- Reset: pc <= RESET_PC; state <= FETCH; pc_if_id <= 0; instr_if_id <= NOP_INSTR; valid_if_id <= 0; hold buffer cleared. Outputs are registered except imem_req/imem_addr/fetch_busy, which are combinational from state and pc.
- The memory shares rst; no response for a pre-reset request may arrive after reset, and the block is not required to tolerate one.
- advance = pc_write & if_id_write. Either signal low stalls both the PC and IF/ID.
- States: FETCH, WAIT, HOLD, DRAIN. At most one outstanding request.
- FETCH:
  - imem_req = ~branch_taken; imem_addr = pc.
  - On handshake -> WAIT. PC is not incremented at grant.
- WAIT:
  - imem_req = 0.
  - On imem_rvalid & advance: IF/ID <= {pc, imem_rdata, 1}; pc <= pc+4; -> FETCH.
  - On imem_rvalid & ~advance: hold_buf <= imem_rdata; IF/ID unchanged; -> HOLD.
  - No rvalid: stay.
- HOLD:
  - imem_req = 0.
  - On advance: IF/ID <= {pc, hold_buf, 1}; pc <= pc+4; -> FETCH.
- DRAIN (a killed request is outstanding):
  - imem_req = 0.
  - On imem_rvalid: drop data -> FETCH.
- Latency: with a 1-cycle memory and no stalls, grant at cycle N, rvalid at N+1, IF/ID valid at N+2. Peak throughput is 1 instruction per 2 cycles.
- Stall while IF/ID valid: IF/ID holds pc/instr/valid unchanged whenever if_id_write=0, including in FETCH/WAIT states.
- Redirect (branch_taken=1): highest priority, overrides stall and any response.
  - pc <= {branch_target[XLEN-1:2], 2'b00}.
  - IF/ID <= {0, NOP_INSTR, 0} regardless of if_id_write.
  - FETCH -> FETCH; imem_req is suppressed that cycle, so no grant is possible.
  - WAIT with imem_rvalid same cycle -> FETCH; response dropped.
  - WAIT without rvalid -> DRAIN.
  - HOLD -> FETCH; hold_buf discarded.
  - DRAIN with rvalid -> FETCH; without rvalid -> stays DRAIN. pc takes the newest target in both cases.
- PC arithmetic is modulo 2^XLEN: pc 32'hFFFF_FFFC + 4 wraps to 0.
- Unreachable state encodings return to FETCH on the next clock.

Test Plan:
1. Reset, then 1-cycle memory always granting, advance=1:
   - imem_addr 0x0, 0x4, 0x8 on alternate cycles.
   - IF/ID shows (0x0,I0,1), (0x4,I1,1), (0x8,I2,1) two cycles apart.
2. Load-use stall: pc_write=if_id_write=0 for 3 cycles while response 0x00A00093 arrives in WAIT:
   - state goes HOLD; IF/ID is unchanged during the stall; no imem_req.
   - on release, IF/ID = (pc, 0x00A00093, 1) and pc += 4.
3. Redirect in WAIT (rvalid delayed 3 cycles), branch_target=0x103:
   - IF/ID becomes (0, 0x13, 0); state DRAIN.
   - the late response is dropped; next imem_addr = 0x100.
4. Redirect coincident with rvalid and with stall asserted:
   - the response is not loaded; valid_if_id=0; next imem_addr = target; no HOLD entry.
5. imem_gnt held low 4 cycles:
   - imem_req stays 1 with a stable imem_addr; fetch_busy=0.
   - after grant, fetch_busy=1 until delivery.
6. Wrap-around and reset mid-operation:
   - with pc=0xFFFF_FFFC, delivery makes the next imem_addr 0x0.
   - rst asserted in HOLD: next cycle state FETCH, pc=RESET_PC, valid_if_id=0.
